// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the CPU sequencer slice.
//   opcode_e  : 3-bit instruction opcodes
//   step_e    : sequencer step encodings S0..S7
//   strobes_t : bundle of datapath strobes produced by the decode
//   is_mem_op : true for opcodes that read a memory operand into the ACC
package cpu_pkg;

  localparam int SEQ_LEN_DEFAULT = 8;

  typedef enum logic [2:0] {
    OP_HLT  = 3'b000,
    OP_SKZ  = 3'b001,
    OP_ADD  = 3'b010,
    OP_ANDD = 3'b011,
    OP_XORR = 3'b100,
    OP_LDA  = 3'b101,
    OP_STO  = 3'b110,
    OP_JMP  = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
    S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
  } step_e;

  typedef struct packed {
    logic inc_pc;
    logic load_acc;
    logic load_pc;
    logic rd;
    logic wr;
    logic load_ir;
    logic datactl_ena;
  } strobes_t;

  // Opcodes whose execute phase reads memory and loads the accumulator.
  function automatic logic is_mem_op(input opcode_e op);
    logic r;
    case (op)
      OP_ADD, OP_ANDD, OP_XORR, OP_LDA: r = 1'b1;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if -- bus between the controlling environment and the
// sequencer.
//   Controls (master -> slave): ena, opcode, zero [, fetch]
//   Results  (slave -> master): inc_pc, load_acc, load_pc, rd, wr, load_ir,
//                               datactl_ena, halt, step [, sync_err]
// Optional: SEQ_SYNC_CHECK_EN adds the fetch / sync_err pair.
interface cpu_sequencer_if;
  logic       ena;
  logic [2:0] opcode;
  logic       zero;
  logic       inc_pc;
  logic       load_acc;
  logic       load_pc;
  logic       rd;
  logic       wr;
  logic       load_ir;
  logic       datactl_ena;
  logic       halt;
  logic [2:0] step;
`ifdef SEQ_SYNC_CHECK_EN
  logic       fetch;
  logic       sync_err;

  modport master (
    output ena, opcode, zero, fetch,
    input  inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena,
           halt, step, sync_err
  );
  modport slave (
    input  ena, opcode, zero, fetch,
    output inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena,
           halt, step, sync_err
  );
`else
  modport master (
    output ena, opcode, zero,
    input  inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena,
           halt, step
  );
  modport slave (
    input  ena, opcode, zero,
    output inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena,
           halt, step
  );
`endif
endinterface

// File: rtl/seq_op_decode.sv
// seq_op_decode -- combinational strobe decode from step, opcode and zero.
//   active_i  : 1 when the sequencer may drive strobes (ena, not halted,
//               not in reset); 0 forces every strobe low
//   step_i    : current step
//   opcode_i  : instruction opcode
//   zero_i    : accumulator-zero flag (only looked at in S5/S7)
//   strobes_o : decoded datapath strobes
module seq_op_decode
  import cpu_pkg::*;
(
  input  logic     active_i,
  input  step_e    step_i,
  input  opcode_e  opcode_i,
  input  logic     zero_i,
  output strobes_t strobes_o
);

  // Step/opcode decode; rd and wr are never set together in any branch.
  always_comb begin
    strobes_o = '0;
    if (active_i) begin
      case (step_i)
        S0: begin
          strobes_o.rd      = 1'b1;
          strobes_o.load_ir = 1'b1;
        end
        S1: begin
          strobes_o.rd      = 1'b1;
          strobes_o.load_ir = 1'b1;
          strobes_o.inc_pc  = 1'b1;
        end
        S2: strobes_o = '0;
        S3: strobes_o.inc_pc = 1'b1;
        S4: begin
          case (opcode_i)
            OP_ADD, OP_ANDD, OP_XORR, OP_LDA: strobes_o.rd = 1'b1;
            OP_STO:  strobes_o.datactl_ena = 1'b1;
            default: strobes_o = '0;
          endcase
        end
        S5: begin
          case (opcode_i)
            OP_ADD, OP_ANDD, OP_XORR, OP_LDA: begin
              strobes_o.rd       = 1'b1;
              strobes_o.load_acc = 1'b1;
            end
            OP_STO: begin
              strobes_o.wr          = 1'b1;
              strobes_o.datactl_ena = 1'b1;
            end
            OP_JMP: begin
              strobes_o.load_pc = 1'b1;
              strobes_o.inc_pc  = 1'b1;
            end
            OP_SKZ:  strobes_o.inc_pc = zero_i;
            default: strobes_o = '0;
          endcase
        end
        S6: begin
          case (opcode_i)
            OP_ADD, OP_ANDD, OP_XORR, OP_LDA: begin
              strobes_o.rd       = 1'b1;
              strobes_o.load_acc = 1'b1;
            end
            OP_STO:  strobes_o.datactl_ena = 1'b1;
            OP_JMP:  strobes_o.load_pc = 1'b1;
            default: strobes_o = '0;
          endcase
        end
        S7: begin
          case (opcode_i)
            OP_SKZ:  strobes_o.inc_pc = zero_i;
            default: strobes_o = '0;
          endcase
        end
        default: strobes_o = '0;
      endcase
    end else begin
      strobes_o = '0;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer -- 8-step instruction sequencer with sticky halt.
//   sys_clk : system clock, rising edge
//   rst     : asynchronous active-high reset
//   bus     : cpu_sequencer_if.slave (ena/opcode/zero in; strobes, halt,
//             step out)
// Optional: SEQ_SYNC_CHECK_EN adds fetch input and sticky sync_err output;
// a fetch rising edge outside S0 flags sync_err and resynchronises to S0.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int SEQ_LEN = SEQ_LEN_DEFAULT
) (
  input  logic          sys_clk,
  input  logic          rst,
  cpu_sequencer_if.slave bus
);

  localparam logic [2:0] LAST_STEP = 3'(SEQ_LEN - 1);

  step_e    step_q, step_d;
  logic     halt_q, halt_d;
  strobes_t strobes_s;
  opcode_e  opcode_s;
  logic     active_s;

  assign opcode_s = opcode_e'(bus.opcode);
  // Reset gates strobes too, so S0 fetch strobes never leak during rst.
  assign active_s = bus.ena & ~halt_q & ~rst;

`ifdef SEQ_SYNC_CHECK_EN
  logic fetch_q;
  logic sync_err_q, sync_err_d;
  logic fetch_rise_s;

  assign fetch_rise_s = bus.fetch & ~fetch_q;
`endif

  // State registers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      step_q <= S0;
      halt_q <= 1'b0;
`ifdef SEQ_SYNC_CHECK_EN
      fetch_q    <= 1'b0;
      sync_err_q <= 1'b0;
`endif
    end else begin
      step_q <= step_d;
      halt_q <= halt_d;
`ifdef SEQ_SYNC_CHECK_EN
      fetch_q    <= bus.fetch;
      sync_err_q <= sync_err_d;
`endif
    end
  end

  // Next step / halt; a HLT in S3 latches halt and freezes step at S3.
  always_comb begin
    step_d = step_q;
    halt_d = halt_q;
`ifdef SEQ_SYNC_CHECK_EN
    sync_err_d = sync_err_q;
`endif
    if (halt_q) begin
      step_d = step_q;
    end else if (bus.ena) begin
      if ((step_q == S3) && (opcode_s == OP_HLT)) begin
        halt_d = 1'b1;
      end else if (step_q == step_e'(LAST_STEP)) begin
        step_d = S0;
      end else begin
        step_d = step_e'(step_q + 3'd1);
      end
    end else begin
      step_d = step_q;
    end
`ifdef SEQ_SYNC_CHECK_EN
    // Clock-generator fetch phase must coincide with S0; otherwise resync.
    if (!halt_q && fetch_rise_s && (step_q != S0)) begin
      sync_err_d = 1'b1;
      step_d     = S0;
    end else begin
      sync_err_d = sync_err_d;
    end
`endif
  end

  seq_op_decode u_decode (
    .active_i  (active_s),
    .step_i    (step_q),
    .opcode_i  (opcode_s),
    .zero_i    (bus.zero),
    .strobes_o (strobes_s)
  );

  assign bus.inc_pc      = strobes_s.inc_pc;
  assign bus.load_acc    = strobes_s.load_acc;
  assign bus.load_pc     = strobes_s.load_pc;
  assign bus.rd          = strobes_s.rd;
  assign bus.wr          = strobes_s.wr;
  assign bus.load_ir     = strobes_s.load_ir;
  assign bus.datactl_ena = strobes_s.datactl_ena;
  assign bus.halt        = halt_q;
  assign bus.step        = step_q;
`ifdef SEQ_SYNC_CHECK_EN
  assign bus.sync_err    = sync_err_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer -- directed self-checking bench for cpu_sequencer.
// Strobe vector packing: {inc_pc, load_acc, load_pc, rd, wr, load_ir,
// datactl_ena}. Define SEQ_SYNC_CHECK_EN to also exercise fetch/sync_err.
module tb_cpu_sequencer;

  logic sys_clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  cpu_sequencer_if bus ();

  cpu_sequencer #(.SEQ_LEN(8)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Expected strobe patterns, index = step.
  logic [6:0] exp_add [8];
  logic [6:0] exp_sto [8];
  logic [6:0] exp_skz1[8];
  logic [6:0] exp_skz0[8];
  logic [6:0] exp_jmp [8];

  function automatic logic [6:0] strobes();
    return {bus.inc_pc, bus.load_acc, bus.load_pc, bus.rd, bus.wr,
            bus.load_ir, bus.datactl_ena};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Walk steps first..last; zero follows zmask[step]; checks then advances.
  task automatic run_steps(input logic [2:0] op, input logic [7:0] zmask,
                           input logic [6:0] exp [8], input int first,
                           input int last, input string name);
    bus.opcode = op;
    for (int i = first; i <= last; i++) begin
      bus.zero = zmask[i];
      #1;
      check_eq($sformatf("%s_step%0d", name, i), 32'(bus.step), 32'(i));
      check_eq($sformatf("%s_strb%0d", name, i), 32'(strobes()), 32'(exp[i]));
      tick();
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //                 S0     S1     S2     S3     S4     S5     S6     S7
    exp_add  = '{7'h0A, 7'h4A, 7'h00, 7'h40, 7'h08, 7'h28, 7'h28, 7'h00};
    exp_sto  = '{7'h0A, 7'h4A, 7'h00, 7'h40, 7'h01, 7'h05, 7'h01, 7'h00};
    exp_skz1 = '{7'h0A, 7'h4A, 7'h00, 7'h40, 7'h00, 7'h40, 7'h00, 7'h40};
    exp_skz0 = '{7'h0A, 7'h4A, 7'h00, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00};
    exp_jmp  = '{7'h0A, 7'h4A, 7'h00, 7'h40, 7'h00, 7'h50, 7'h10, 7'h00};

    // Reset with ena high: strobes must still be low.
    rst        = 1'b1;
    bus.ena    = 1'b1;
    bus.opcode = 3'b010;
    bus.zero   = 1'b0;
`ifdef SEQ_SYNC_CHECK_EN
    bus.fetch  = 1'b0;
`endif
    #2;
    check_eq("rst_step", 32'(bus.step), 32'd0);
    check_eq("rst_halt", 32'(bus.halt), 32'd0);
    check_eq("rst_strb", 32'(strobes()), 32'd0);
`ifdef SEQ_SYNC_CHECK_EN
    check_eq("rst_sync_err", 32'(bus.sync_err), 32'd0);
`endif
    tick();
    check_eq("rst_hold_step", 32'(bus.step), 32'd0);
    @(negedge sys_clk);
    rst = 1'b0;

    run_steps(3'b010, 8'h00, exp_add,  0, 7, "add");
    run_steps(3'b011, 8'h00, exp_add,  0, 7, "andd");
    run_steps(3'b110, 8'h00, exp_sto,  0, 7, "sto");
    run_steps(3'b001, 8'hFF, exp_skz1, 0, 7, "skz1");
    run_steps(3'b001, 8'h00, exp_skz0, 0, 7, "skz0");
    // zero high only outside S5/S7: no skip increments expected.
    run_steps(3'b001, 8'h5F, exp_skz0, 0, 7, "skzmask");

    // JMP with ena dropped at S4 for 3 cycles.
    run_steps(3'b111, 8'h00, exp_jmp, 0, 3, "jmp");
    bus.ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("jmp_hold_step", 32'(bus.step), 32'd4);
      check_eq("jmp_hold_strb", 32'(strobes()), 32'd0);
      tick();
    end
    bus.ena = 1'b1;
    run_steps(3'b111, 8'h00, exp_jmp, 4, 7, "jmpres");

    // ena low at S0 gates the fetch strobes and holds step.
    bus.ena = 1'b0;
    #1;
    check_eq("ena0_strb", 32'(strobes()), 32'd0);
    tick();
    check_eq("ena0_step", 32'(bus.step), 32'd0);
    bus.ena = 1'b1;

    // HLT: halt after S3, then frozen regardless of ena/opcode.
    run_steps(3'b000, 8'h00, exp_add, 0, 3, "hlt");
    check_eq("hlt_halt", 32'(bus.halt), 32'd1);
    for (int i = 0; i < 20; i++) begin
      bus.ena    = i[0];
      bus.opcode = (i < 10) ? 3'b010 : 3'b000;
      #1;
      check_eq("hlt_step", 32'(bus.step), 32'd3);
      check_eq("hlt_sticky", 32'(bus.halt), 32'd1);
      check_eq("hlt_strb", 32'(strobes()), 32'd0);
      tick();
    end
    bus.ena = 1'b1;
    rst     = 1'b1;
    #1;
    check_eq("hlt_rst_step", 32'(bus.step), 32'd0);
    check_eq("hlt_rst_halt", 32'(bus.halt), 32'd0);
    @(negedge sys_clk);
    rst = 1'b0;

    // Reset mid-instruction: abandon and restart at S0.
    run_steps(3'b110, 8'h00, exp_sto, 0, 4, "sto_part");
    rst = 1'b1;
    #1;
    check_eq("mid_rst_step", 32'(bus.step), 32'd0);
    @(negedge sys_clk);
    rst = 1'b0;
    run_steps(3'b010, 8'h00, exp_add, 0, 7, "add_after_rst");

`ifdef SEQ_SYNC_CHECK_EN
    // Fetch rising edge at S5 -> resync to S0 and sticky sync_err.
    run_steps(3'b010, 8'h00, exp_add, 0, 4, "sync_pre");
    check_eq("sync_at_s5", 32'(bus.step), 32'd5);
    check_eq("sync_err_pre", 32'(bus.sync_err), 32'd0);
    bus.fetch = 1'b1;
    tick();
    check_eq("sync_step", 32'(bus.step), 32'd0);
    check_eq("sync_err_set", 32'(bus.sync_err), 32'd1);
    bus.fetch = 1'b0;
    tick();
    check_eq("sync_step_next", 32'(bus.step), 32'd1);
    check_eq("sync_err_sticky", 32'(bus.sync_err), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter: SEQ_LEN, default 8, number of sequencer steps per instruction; only the value 8 is supported.
REQ-002 Port: sys_clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: ena  input  1  step enable; sequencer advances only while high.
REQ-005 Port: opcode  input  3  instruction opcode from the instruction register: HLT=000, SKZ=001, ADD=010, ANDD=011, XORR=100, LDA=101, STO=110, JMP=111.
REQ-006 Port: zero  input  1  accumulator-zero flag.
REQ-007 Port: inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena  output  1 each  datapath strobes.
REQ-008 Port: halt  output  1  processor halted, sticky.
REQ-009 Port: step  output  3  current step index, S0..S7.

Function
REQ-010 A 3-bit step register SHALL advance S0->S1->...->S7->S0, one step per cycle while ena=1, and hold while ena=0.
REQ-011 All strobes SHALL be a combinational decode of the registered step, opcode and zero, and SHALL be 0 whenever ena=0 or halt=1.
REQ-012 In S0, rd and load_ir SHALL be 1 (opcode byte fetch).
REQ-013 In S1, rd, load_ir and inc_pc SHALL be 1.
REQ-014 In S2, all strobes SHALL be 0.
REQ-015 In S3, inc_pc SHALL be 1; if opcode=HLT, halt SHALL set on the next edge.
REQ-016 In S4: ADD/ANDD/XORR/LDA -> rd=1; STO -> datactl_ena=1; other opcodes -> all strobes 0.
REQ-017 In S5: ADD/ANDD/XORR/LDA -> rd=1 and load_acc=1; STO -> wr=1 and datactl_ena=1; JMP -> load_pc=1 and inc_pc=1; SKZ with zero=1 -> inc_pc=1.
REQ-018 In S6: ADD/ANDD/XORR/LDA -> rd=1 and load_acc=1; STO -> datactl_ena=1; JMP -> load_pc=1.
REQ-019 In S7: SKZ with zero=1 -> inc_pc=1; all other cases -> all strobes 0.
REQ-020 At most one of rd and wr SHALL be high in any cycle.
REQ-021 Once set, halt SHALL remain 1 and step SHALL freeze until rst; ena has no effect while halted.
REQ-022 zero SHALL be sampled in S5 and S7 only; changes in other steps have no effect.
REQ-023 ena deasserted mid-instruction SHALL freeze step; resuming SHALL continue from the frozen step.

Reset
REQ-024 rst=1 SHALL immediately force step=S0 and halt=0, and force all strobes to 0 regardless of ena.
REQ-025 Reset asserted mid-instruction SHALL abandon the instruction, and the first step after release SHALL be S0.

Configuration
REQ-026 With SEQ_SYNC_CHECK_EN defined: extra ports fetch (input 1, clock-generator fetch phase) and sync_err (output 1, sticky, reset 0) SHALL exist. A fetch rising edge seen while step is not S0 SHALL set sync_err and force step to S0 on the same edge.
REQ-027 With SEQ_SYNC_CHECK_EN undefined: the fetch and sync_err ports SHALL be absent and no fetch-edge register SHALL exist.

Structure
REQ-028 Opcode constants and step encodings SHALL live in the shared package cpu_pkg.
REQ-029 The strobe decode SHALL be a separate combinational sub-module, seq_op_decode; cpu_sequencer holds the step, halt and sync registers.

Verification
REQ-030 ADD (010) with ena=1 for 8 cycles: rd=1 in S0, S1, S4, S5, S6; load_acc=1 in S5 and S6; inc_pc=1 in S1 and S3; wr never 1.
REQ-031 STO (110): datactl_ena=1 in S4, S5, S6; wr=1 only in S5; rd=0 in S4 through S7.
REQ-032 SKZ (001): with zero=1, inc_pc=1 in S1, S3, S5, S7; with zero=0, inc_pc=1 in S1 and S3 only.
REQ-033 HLT (000): halt=1 from the cycle after S3; step stays 3 and all strobes stay 0 for 20 further cycles; rst pulse -> step=0, halt=0.
REQ-034 ena dropped for 3 cycles at S4 of a JMP: step holds at 4 with strobes 0; on resume, load_pc=1 in S5 and S6.
REQ-035 SEQ_SYNC_CHECK_EN defined, fetch rising edge at S5: sync_err=1 (sticky) and step=0 on the next cycle; with the macro undefined, the build has no fetch port.
